// File: rtl/rvi_addsub_pkg.sv
// Shared definitions for the RVI add/sub issue block.
// Contents: opcode and funct constants for the integer add/sub/set-less-than
// subset, the add/sub op encoding, and the issue entry struct that is passed
// from the decoder to the FIFO.
// The struct carries operands at the widest supported width (64 bits). A
// 32-bit instance uses only the low half and leaves the upper bits zero.

package rvi_addsub_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_SLTU   = 3'b011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // op[0]=add, op[1]=sub, op[2]=word result
    localparam logic [2:0] ADDSUB_OP_NONE = 3'b000;
    localparam logic [2:0] ADDSUB_OP_ADD  = 3'b001;
    localparam logic [2:0] ADDSUB_OP_SUB  = 3'b010;
    localparam logic [2:0] ADDSUB_OP_ADDW = 3'b101;
    localparam logic [2:0] ADDSUB_OP_SUBW = 3'b110;

    typedef struct packed {
        logic [2:0]          op;
        logic [XLEN_MAX-1:0] s1;
        logic [XLEN_MAX-1:0] s2;
        logic                is_unsigned;
        logic                slt;
        logic [4:0]          rd;
        logic                illegal;
    } addsub_issue_t;

endpackage

// File: rtl/rvi_addsub_decode.sv
// Combinational decoder for the integer add/sub/set-less-than subset.
// Ports:
//   inst_i  - 32-bit instruction word
//   rs1_i   - rs1 register value
//   rs2_i   - rs2 register value
//   dec_o   - decoded issue entry (op, operands, compare flags, rd, illegal)
// Anything outside the subset decodes to illegal with op, flags and operands
// cleared; rd is always taken from inst[11:7].

module rvi_addsub_decode
    import rvi_addsub_pkg::*;
#(
    parameter int CPU_WIDTH = 64
) (
    input  logic [31:0]          inst_i,
    input  logic [CPU_WIDTH-1:0] rs1_i,
    input  logic [CPU_WIDTH-1:0] rs2_i,
    output addsub_issue_t        dec_o
);

    localparam bit HAS_WORD_OPS = (CPU_WIDTH == 64);

    logic [6:0]           opcode;
    logic [2:0]           f3;
    logic [6:0]           f7;
    logic [CPU_WIDTH-1:0] imm;

    logic       legal;
    logic       use_imm;
    logic [2:0] op;
    logic       slt;
    logic       uns;

    assign opcode = inst_i[6:0];
    assign f3     = inst_i[14:12];
    assign f7     = inst_i[31:25];
    assign imm    = {{(CPU_WIDTH-12){inst_i[31]}}, inst_i[31:20]};

    always_comb begin
        legal   = 1'b0;
        use_imm = 1'b0;
        op      = ADDSUB_OP_NONE;
        slt     = 1'b0;
        uns     = 1'b0;

        case (opcode)
            OPC_OP: begin
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADDSUB: begin legal = 1'b1; op = ADDSUB_OP_ADD; end
                        F3_SLT:    begin legal = 1'b1; op = ADDSUB_OP_SUB; slt = 1'b1; end
                        F3_SLTU:   begin legal = 1'b1; op = ADDSUB_OP_SUB; slt = 1'b1; uns = 1'b1; end
                        default:   legal = 1'b0;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADDSUB) begin
                    legal = 1'b1;
                    op    = ADDSUB_OP_SUB;
                end
            end
            OPC_OP_IMM: begin
                use_imm = 1'b1;
                case (f3)
                    F3_ADDSUB: begin legal = 1'b1; op = ADDSUB_OP_ADD; end
                    F3_SLT:    begin legal = 1'b1; op = ADDSUB_OP_SUB; slt = 1'b1; end
                    // SLTIU: immediate is sign-extended, then compared unsigned
                    F3_SLTU:   begin legal = 1'b1; op = ADDSUB_OP_SUB; slt = 1'b1; uns = 1'b1; end
                    default:   legal = 1'b0;
                endcase
            end
            OPC_OP_32: begin
                if (HAS_WORD_OPS && f3 == F3_ADDSUB) begin
                    if (f7 == F7_BASE) begin
                        legal = 1'b1;
                        op    = ADDSUB_OP_ADDW;
                    end else if (f7 == F7_ALT) begin
                        legal = 1'b1;
                        op    = ADDSUB_OP_SUBW;
                    end
                end
            end
            OPC_OP_IMM_32: begin
                if (HAS_WORD_OPS && f3 == F3_ADDSUB) begin
                    legal   = 1'b1;
                    use_imm = 1'b1;
                    op      = ADDSUB_OP_ADDW;
                end
            end
            default: legal = 1'b0;
        endcase

        dec_o    = '0;
        dec_o.rd = inst_i[11:7];
        if (legal) begin
            dec_o.op                   = op;
            dec_o.slt                  = slt;
            dec_o.is_unsigned          = uns;
            dec_o.s1[CPU_WIDTH-1:0]    = rs1_i;
            dec_o.s2[CPU_WIDTH-1:0]    = use_imm ? imm : rs2_i;
        end else begin
            dec_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/rvi_addsub_issue.sv
// Issue-side initiator for the RVI add/sub execute interface.
// Decodes incoming instructions and queues them in a 2-entry FIFO that feeds
// the add/sub execute unit and its less-than comparator.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   flush            - discard all buffered entries
//   in_vld/in_rdy    - instruction handshake (in_rdy from registered count only)
//   in_inst/in_rs1/in_rs2 - instruction word and register operands
//   out_vld/out_rdy  - execute-side handshake for the head entry
//   out_op, out_s1, out_s2, out_unsigned, out_slt, out_rd, out_illegal
//                    - head entry payload, driven from storage only (1-cycle latency)

module rvi_addsub_issue
    import rvi_addsub_pkg::*;
#(
    parameter int CPU_WIDTH = 64,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [31:0]          in_inst,
    input  logic [CPU_WIDTH-1:0] in_rs1,
    input  logic [CPU_WIDTH-1:0] in_rs2,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [2:0]           out_op,
    output logic [CPU_WIDTH-1:0] out_s1,
    output logic [CPU_WIDTH-1:0] out_s2,
    output logic                 out_unsigned,
    output logic                 out_slt,
    output logic [4:0]           out_rd,
    output logic                 out_illegal
);

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    addsub_issue_t dec;
    addsub_issue_t mem_q [2];
    addsub_issue_t head;

    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       head_idx;
    logic       push;
    logic       pop;

    rvi_addsub_decode #(
        .CPU_WIDTH (CPU_WIDTH)
    ) u_decode (
        .inst_i (in_inst),
        .rs1_i  (in_rs1),
        .rs2_i  (in_rs2),
        .dec_o  (dec)
    );

    assign in_rdy  = (count_q != FULL_COUNT);
    assign out_vld = (count_q != 2'd0);
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push && !flush) begin
                mem_q[wr_ptr_q] <= dec;
            end
        end
    end

    // When empty after a pop, the read pointer has already moved on; looking
    // one slot back keeps the outputs on the entry that was last presented.
    assign head_idx = (count_q == 2'd0) ? ~rd_ptr_q : rd_ptr_q;
    assign head     = mem_q[head_idx];

    assign out_op       = head.op;
    assign out_s1       = head.s1[CPU_WIDTH-1:0];
    assign out_s2       = head.s2[CPU_WIDTH-1:0];
    assign out_unsigned = head.is_unsigned;
    assign out_slt      = head.slt;
    assign out_rd       = head.rd;
    assign out_illegal  = head.illegal;

endmodule

// File: tb/tb_rvi_addsub_issue.sv
module tb_rvi_addsub_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_vld;
    logic [31:0] in_inst;
    logic [63:0] in_rs1;
    logic [63:0] in_rs2;
    logic        out_rdy;

    logic        in_rdy, out_vld, out_unsigned, out_slt, out_illegal;
    logic [2:0]  out_op;
    logic [63:0] out_s1, out_s2;
    logic [4:0]  out_rd;

    logic        w_in_rdy, w_out_vld, w_out_unsigned, w_out_slt, w_out_illegal;
    logic [2:0]  w_out_op;
    logic [31:0] w_out_s1, w_out_s2;
    logic [4:0]  w_out_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rvi_addsub_issue #(.CPU_WIDTH(64), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_inst(in_inst),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_op(out_op),
        .out_s1(out_s1), .out_s2(out_s2), .out_unsigned(out_unsigned),
        .out_slt(out_slt), .out_rd(out_rd), .out_illegal(out_illegal)
    );

    rvi_addsub_issue #(.CPU_WIDTH(32), .DEPTH(2)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_vld(in_vld), .in_rdy(w_in_rdy), .in_inst(in_inst),
        .in_rs1(in_rs1[31:0]), .in_rs2(in_rs2[31:0]),
        .out_vld(w_out_vld), .out_rdy(out_rdy), .out_op(w_out_op),
        .out_s1(w_out_s1), .out_s2(w_out_s2), .out_unsigned(w_out_unsigned),
        .out_slt(w_out_slt), .out_rd(w_out_rd), .out_illegal(w_out_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_vld = 1'b0; in_inst = '0;
        in_rs1 = '0; in_rs2 = '0; out_rdy = 1'b0;

        // reset for two cycles, then idle
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_in_rdy",  64'(in_rdy),  64'd1);
        chk("rst_out_op",  64'(out_op),  64'd0);
        chk("rst_out_s1",  out_s1,       64'd0);

        // ADD x3,x1,x2
        in_vld = 1'b1; in_inst = 32'h002081B3; in_rs1 = 64'd5; in_rs2 = 64'd7; out_rdy = 1'b1;
        tick();
        in_vld = 1'b0;
        chk("add_vld",     64'(out_vld),     64'd1);
        chk("add_op",      64'(out_op),      64'd1);
        chk("add_s1",      out_s1,           64'd5);
        chk("add_s2",      out_s2,           64'd7);
        chk("add_rd",      64'(out_rd),      64'd3);
        chk("add_illegal", 64'(out_illegal), 64'd0);
        chk("add_slt",     64'(out_slt),     64'd0);
        chk("add32_op",    64'(w_out_op),    64'd1);
        chk("add32_s1",    64'(w_out_s1),    64'd5);
        tick();
        chk("add_popped",  64'(out_vld),     64'd0);

        // SLTIU x5,x1,-1 then SUBW x3,x1,x2 pushed while SLTIU pops
        in_vld = 1'b1; in_inst = 32'hFFF0B293; in_rs1 = 64'd3; in_rs2 = 64'd99;
        tick();
        in_inst = 32'h402081BB; in_rs1 = 64'd10; in_rs2 = 64'd4;
        chk("sltiu_op",  64'(out_op),       64'd2);
        chk("sltiu_slt", 64'(out_slt),      64'd1);
        chk("sltiu_uns", 64'(out_unsigned), 64'd1);
        chk("sltiu_s1",  out_s1,            64'd3);
        chk("sltiu_s2",  out_s2,            64'hFFFF_FFFF_FFFF_FFFF);
        chk("sltiu_rd",  64'(out_rd),       64'd5);
        chk("sltiu32_s2", 64'(w_out_s2),    64'hFFFF_FFFF);
        tick();
        in_vld = 1'b0;
        chk("subw_vld", 64'(out_vld),  64'd1);
        chk("subw_op",  64'(out_op),   64'd6);
        chk("subw_s1",  out_s1,        64'd10);
        chk("subw_s2",  out_s2,        64'd4);
        chk("subw_slt", 64'(out_slt),  64'd0);
        chk("subw32_illegal", 64'(w_out_illegal), 64'd1);
        tick();
        chk("subw_popped", 64'(out_vld), 64'd0);

        // backpressure: ADDI x4,x1,-5 then ADDW x6,x1,x2
        out_rdy = 1'b0;
        in_vld = 1'b1; in_inst = 32'hFFB08213; in_rs1 = 64'd100; in_rs2 = 64'd55;
        tick();
        chk("bp1_in_rdy", 64'(in_rdy),  64'd1);
        chk("bp1_vld",    64'(out_vld), 64'd1);
        in_inst = 32'h0020833B; in_rs1 = 64'hFFFF_FFFF_0000_0001; in_rs2 = 64'd2;
        tick();
        chk("bp2_in_rdy", 64'(in_rdy),  64'd0);
        chk("bp2_head_op", 64'(out_op), 64'd1);
        // third instruction offered while full
        in_inst = 32'h002081B3; in_rs1 = 64'd77; in_rs2 = 64'd88;
        tick();
        chk("bp3_in_rdy",  64'(in_rdy),  64'd0);
        chk("bp3_hold_op", 64'(out_op),  64'd1);
        chk("bp3_hold_s1", out_s1,       64'd100);
        chk("bp3_hold_s2", out_s2,       64'hFFFF_FFFF_FFFF_FFFB);
        chk("bp3_hold_rd", 64'(out_rd),  64'd4);
        // full, out_rdy=1 and in_vld=1: pop only
        out_rdy = 1'b1;
        tick();
        in_vld = 1'b0;
        chk("pop1_in_rdy", 64'(in_rdy),  64'd1);
        chk("pop1_vld",    64'(out_vld), 64'd1);
        chk("addw_op",     64'(out_op),  64'd5);
        chk("addw_s1",     out_s1,       64'hFFFF_FFFF_0000_0001);
        chk("addw_s2",     out_s2,       64'd2);
        chk("addw_rd",     64'(out_rd),  64'd6);
        chk("addw32_illegal", 64'(w_out_illegal), 64'd1);
        chk("addw32_op",      64'(w_out_op),      64'd0);
        chk("addw32_s1",      64'(w_out_s1),      64'd0);
        chk("addw32_rd",      64'(w_out_rd),      64'd6);
        tick();
        chk("held_not_pushed", 64'(out_vld), 64'd0);

        // fill with ADD then SUB x3,x1,x2
        out_rdy = 1'b0;
        in_vld = 1'b1; in_inst = 32'h002081B3; in_rs1 = 64'd1; in_rs2 = 64'd2;
        tick();
        in_inst = 32'h402081B3; in_rs1 = 64'd8; in_rs2 = 64'd3;
        tick();
        in_vld = 1'b0;
        chk("fill_in_rdy", 64'(in_rdy), 64'd0);
        chk("fill_head",   64'(out_op), 64'd1);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk("sub_op", 64'(out_op), 64'd2);
        chk("sub_s1", out_s1,      64'd8);
        chk("sub_s2", out_s2,      64'd3);
        // refill with ADDI, then flush with push and pop requested
        in_vld = 1'b1; in_inst = 32'hFFB08213; in_rs1 = 64'd9;
        tick();
        chk("refill_in_rdy", 64'(in_rdy), 64'd0);
        flush = 1'b1; out_rdy = 1'b1; in_inst = 32'h002081B3;
        tick();
        flush = 1'b0; in_vld = 1'b0;
        chk("flush_vld",    64'(out_vld), 64'd0);
        chk("flush_in_rdy", 64'(in_rdy),  64'd1);
        tick();
        chk("flush_stays_empty", 64'(out_vld), 64'd0);

        // illegal encoding is still queued
        in_vld = 1'b1; in_inst = 32'h0000007F; in_rs1 = 64'd55; in_rs2 = 64'd66;
        tick();
        in_vld = 1'b0;
        chk("ill_vld",  64'(out_vld),     64'd1);
        chk("ill_flag", 64'(out_illegal), 64'd1);
        chk("ill_op",   64'(out_op),      64'd0);
        chk("ill_s1",   out_s1,           64'd0);
        chk("ill_s2",   out_s2,           64'd0);
        chk("ill_slt",  64'(out_slt),     64'd0);
        tick();
        chk("ill_popped", 64'(out_vld), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvi_addsub_issue.md
Name: rvi_addsub_issue

Overview:
- Issue-side initiator for the RVI add/sub execute interface.
- Accepts decoded-stage instruction words with register operands over a valid/ready handshake. Decodes the integer add/sub/set-less-than subset into the add/sub op encoding, source operands and compare flags.
- Buffers results in a 2-entry FIFO and presents them to the add/sub execute unit and its less-than comparator.
- Sits between register read and the integer ALU.

Parameters:
- CPU_WIDTH, 64, datapath width; 32 or 64. When 32, OP-32/OP-IMM-32 are illegal.
- DEPTH, 2, FIFO entries; fixed at 2 in this revision.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all buffered entries
- in_vld  in  1  instruction valid
- in_rdy  out  1  buffer can accept; equals (count != DEPTH), driven from registered count only
- in_inst  in  32  RISC-V instruction word
- in_rs1  in  CPU_WIDTH  rs1 value
- in_rs2  in  CPU_WIDTH  rs2 value
- out_vld  out  1  head entry valid
- out_rdy  in  1  execute unit accepts head
- out_op  out  3  add/sub op: [0]=add, [1]=sub, [2]=word (32-bit result sign-extended)
- out_s1  out  CPU_WIDTH  operand 1
- out_s2  out  CPU_WIDTH  operand 2
- out_unsigned  out  1  unsigned compare flag for the less-than unit
- out_slt  out  1  result is the less-than bit, not the sum/difference
- out_rd  out  5  destination register, inst[11:7]
- out_illegal  out  1  instruction not in the supported subset

Behaviour:
- Reset: at a clk edge with rst=1, count=0, rd/wr pointers=0, all stored payload=0.
  - After reset: out_vld=0, all out_* payload=0, in_rdy=1.
  - rst has priority over flush and all handshakes.
- Push: occurs when in_vld & in_rdy. Decode is combinational; the decoded entry is written at the edge.
- Pop: occurs when out_vld & out_rdy. Head advances at the edge.
- Latency: fixed 1 cycle. An entry pushed at edge N is visible at out_* after N. There is no combinational bypass from in_* to out_*.
- Both push and pop in the same cycle: count is unchanged and both pointers advance.
- Full (count=2): in_rdy=0 even if out_rdy=1 in that cycle.
- Empty: out_vld=0; payload outputs hold the last head entry value and must not be interpreted.
- Pointers: 1-bit, wrap 1→0.
- Flush: at the edge, count=0 and pointers=0. Flush wins over a simultaneous push or pop; neither takes effect. in_rdy=1 next cycle.
- Payload stability: while out_vld=1 & out_rdy=0, all out_* hold.
- Decode (imm = sign-extended inst[31:20]):
  - OP 0110011, f7=0000000:
    - f3=000 ADD: op=001
    - f3=010 SLT: op=010, slt=1
    - f3=011 SLTU: op=010, slt=1, unsigned=1
  - OP 0110011, f7=0100000, f3=000 SUB: op=010
  - OP-IMM 0010011, s2=imm:
    - f3=000 ADDI: op=001
    - f3=010 SLTI: op=010, slt=1
    - f3=011 SLTIU: op=010, slt=1, unsigned=1; imm is sign-extended first, then compared unsigned
  - OP-32 0111011, f3=000:
    - f7=0000000 ADDW: op=101
    - f7=0100000 SUBW: op=110
  - OP-IMM-32 0011011, f3=000 ADDIW: op=101, s2=imm
  - s1 is always in_rs1; s2=in_rs2 for register forms.
  - Any other encoding: illegal=1, op=000, slt=0, unsigned=0, s1=s2=0. The entry is still queued.
- Word ops pass full-width operands. Truncation and sign-extension are the execute unit's job.

Decomposition:
- Shared package rvi_addsub_pkg holds:
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32
  - funct3/funct7 constants
  - ADDSUB_OP_ADD=3'b001, SUB=3'b010, ADDW=3'b101, SUBW=3'b110
  - packed struct addsub_issue_t {op, s1, s2, unsigned, slt, rd, illegal}
- One sub-module: rvi_addsub_decode, purely combinational, mapping inst/rs1/rs2 to addsub_issue_t. The top holds the FIFO and handshake.

Test Plan:
- Reset then idle: rst for 2 cycles → out_vld=0, in_rdy=1, out_op=000 at first cycle after rst deasserts.
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_rdy=1 → next cycle out_vld=1, op=001, s1=5, s2=7, rd=3, illegal=0; popped, out_vld=0 the following cycle.
- SLTIU x5,x1,-1 (0xFFF0B293), rs1=3 → op=010, slt=1, unsigned=1, s2=0xFFFF_FFFF_FFFF_FFFF. SUBW 0x402081BB → op=110.
- Backpressure: out_rdy=0, push ADDI, then ADDW back-to-back → in_rdy=0 after second push, third instruction held. Raise out_rdy → ADDI (op=001) then ADDW (op=101) emerge in order. in_rdy=1 one cycle after first pop.
- Full + push + pop cycle: full, out_rdy=1, in_vld=1 → no push that cycle, count drops to 1.
- Flush while full with in_vld=1 → next cycle out_vld=0, in_rdy=1, flushed data never appears. Illegal 0x0000007F → illegal=1, op=000. With CPU_WIDTH=32, ADDW → illegal=1.
